// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer: streams a packed ASCII message into the LCD driver one
// CHUNK_BYTES-wide word at a time. Each pass sends CLEAR, then the message
// chunks, with a line-2 address command placed ahead of the first chunk of
// line 2. Every handshake wait is bounded, so a dead driver ends in ERROR.
module lcd_msg_sequencer #(
    parameter int                     CHUNK_BYTES    = 4,
    parameter int                     MSG_CHARS      = 32,
    parameter int                     LINE_CHARS     = 16,
    parameter logic [8*MSG_CHARS-1:0] MSG            = {MSG_CHARS{8'h20}},
    parameter int                     STARTUP_CYCLES = 5,
    parameter int                     TIMEOUT_CYCLES = 65535,
    parameter int                     REPEAT_GAP     = 50000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     repeat_en,
    input  logic                     lcd_available,
    output logic [8*CHUNK_BYTES-1:0] lcd_data,
    output logic                     lcd_select_cd,
    output logic                     lcd_enable_writing,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [7:0]               word_idx
);
    localparam int W          = 8*CHUNK_BYTES;
    localparam int NCHUNK     = MSG_CHARS/CHUNK_BYTES;
    localparam int LINE_CHUNK = LINE_CHARS/CHUNK_BYTES;
    localparam bit HAS_LINE2  = (LINE_CHUNK < NCHUNK) && (LINE_CHUNK > 0);
    localparam int MAX_AB     = (REPEAT_GAP > TIMEOUT_CYCLES) ? REPEAT_GAP : TIMEOUT_CYCLES;
    localparam int CNT_MAX    = (MAX_AB > STARTUP_CYCLES) ? MAX_AB : STARTUP_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1) + 1;
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((REPEAT_GAP > 0) ? REPEAT_GAP - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, STARTUP, WAIT_READY, ISSUE, WAIT_ACCEPT,
        WAIT_DONE, NEXT, FINISH, GAP, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             armed;     // blocks a start seen on the first edge after reset release
    logic             in_clear;  // current list item is the CLEAR command
    logic             in_line2;  // current list item is the line-2 address command
    logic             start_ok;
    logic             last_item;
    logic             line2_next;
    logic             counting;
    logic             restart;
    logic [W-1:0]     chunk_word;
    logic [W-1:0]     cur_word;

    assign start_ok   = start && armed && (state_q == IDLE || state_q == ERROR);
    assign last_item  = !in_clear && !in_line2 && (word_idx == 8'(NCHUNK - 1));
    assign line2_next = HAS_LINE2 && !in_clear && !in_line2 && (word_idx == 8'(LINE_CHUNK - 1));
    assign counting   = (state_q == STARTUP) || (state_q == WAIT_READY) || (state_q == WAIT_ACCEPT)
                     || (state_q == WAIT_DONE) || (state_q == GAP);
    assign restart    = (state_q == GAP) && (state_d == WAIT_READY);
    // First character lives in the MSBs, so chunk 0 is the topmost slice.
    assign chunk_word = W'(MSG >> (W * (NCHUNK - 1 - int'(word_idx))));
    assign cur_word   = in_clear ? (W'(8'h01) << (W - 8)) :
                        in_line2 ? (W'(8'hC0) << (W - 8)) : chunk_word;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and strobe/status decode.
    always_comb begin
        state_d            = state_q;
        lcd_enable_writing = 1'b0;
        done               = 1'b0;
        busy               = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) state_d = STARTUP;
            end
            STARTUP:     if (cnt == ST_LAST) state_d = WAIT_READY;
            WAIT_READY: begin
                if (lcd_available)       state_d = ISSUE;
                else if (cnt == TO_LAST) state_d = ERROR;
            end
            ISSUE: begin
                lcd_enable_writing = 1'b1;
                state_d            = WAIT_ACCEPT;
            end
            // A high level right after the strobe is stale; wait for the fall first.
            WAIT_ACCEPT: begin
                if (!lcd_available)      state_d = WAIT_DONE;
                else if (cnt == TO_LAST) state_d = ERROR;
            end
            WAIT_DONE: begin
                if (lcd_available)       state_d = NEXT;
                else if (cnt == TO_LAST) state_d = ERROR;
            end
            NEXT:        state_d = last_item ? FINISH : WAIT_READY;
            FINISH: begin
                done    = 1'b1;
                state_d = repeat_en ? GAP : IDLE;
            end
            GAP:         if (cnt == GAP_LAST) state_d = repeat_en ? WAIT_READY : IDLE;
            ERROR: begin
                busy = 1'b0;
                if (start_ok) state_d = STARTUP;
            end
            default:     state_d = IDLE;
        endcase
    end

    // Shared cycle counter for startup, gap and handshake timeouts; reloads on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              cnt <= '0;
        else if (!counting || state_d != state_q) cnt <= '0;
        else                                     cnt <= cnt + CNT_W'(1);
    end

    // Arm start acceptance one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // List pointer: CLEAR, chunks, with the line-2 command ahead of the first line-2 chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_clear <= 1'b1;
            in_line2 <= 1'b0;
            word_idx <= '0;
        end else if (start_ok || restart) begin
            in_clear <= 1'b1;
            in_line2 <= 1'b0;
            word_idx <= '0;
        end else if (state_q == NEXT && !last_item) begin
            if (in_clear)        in_clear <= 1'b0;
            else if (in_line2) begin
                in_line2 <= 1'b0;
                word_idx <= word_idx + 8'd1;
            end
            else if (line2_next) in_line2 <= 1'b1;
            else                 word_idx <= word_idx + 8'd1;
        end
    end

    // Word and data/command select are loaded on entry to ISSUE and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_data      <= '0;
            lcd_select_cd <= 1'b1;
        end else if (state_d == ISSUE && state_q != ISSUE) begin
            lcd_data      <= cur_word;
            lcd_select_cd <= !(in_clear || in_line2);
        end
    end

    // Sticky timeout flag, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   timeout_err <= 1'b0;
        else if (start_ok)                            timeout_err <= 1'b0;
        else if (state_d == ERROR && state_q != ERROR) timeout_err <= 1'b1;
    end
endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed bench for lcd_msg_sequencer: two instances (4-byte and 2-byte words)
// driven by a simple LCD driver model, words captured on each strobe.
module tb_lcd_msg_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_a, start_b, rep_a, dead_a;
    logic        avail_a, avail_b;
    logic [31:0] data_a;
    logic [15:0] data_b;
    logic        cd_a, en_a, busy_a, done_a, err_a;
    logic        cd_b, en_b, busy_b, done_b, err_b;
    logic [7:0]  idx_a, idx_b;

    int n_chk = 0, n_err = 0, cyc = 0;
    int mcnt_a = 0, mcnt_b = 0;
    int done_n_a = 0, done_n_b = 0;
    int done_t_a[$];
    logic [32:0] wq_a[$];
    logic [7:0]  iq_a[$];
    logic [16:0] wq_b[$];

    logic [32:0] exp_a[5] = '{{1'b0, 32'h01000000}, {1'b1, 32'h48454C4C}, {1'b1, 32'h4F205749},
                              {1'b0, 32'hC0000000}, {1'b1, 32'h4C4C2120}};
    logic [16:0] exp_b[4] = '{{1'b0, 16'h0100}, {1'b1, 16'h4142}, {1'b0, 16'hC000}, {1'b1, 16'h4344}};

    lcd_msg_sequencer #(
        .CHUNK_BYTES(4), .MSG_CHARS(12), .LINE_CHARS(8), .MSG("HELLO WILL! "),
        .STARTUP_CYCLES(5), .TIMEOUT_CYCLES(20), .REPEAT_GAP(100)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .repeat_en(rep_a), .lcd_available(avail_a),
        .lcd_data(data_a), .lcd_select_cd(cd_a), .lcd_enable_writing(en_a), .busy(busy_a),
        .done(done_a), .timeout_err(err_a), .word_idx(idx_a)
    );

    lcd_msg_sequencer #(
        .CHUNK_BYTES(2), .MSG_CHARS(4), .LINE_CHARS(2), .MSG("ABCD"),
        .STARTUP_CYCLES(5), .TIMEOUT_CYCLES(20), .REPEAT_GAP(100)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .repeat_en(1'b0), .lcd_available(avail_b),
        .lcd_data(data_b), .lcd_select_cd(cd_b), .lcd_enable_writing(en_b), .busy(busy_b),
        .done(done_b), .timeout_err(err_b), .word_idx(idx_b)
    );

    // Driver model: available drops 2 cycles after the strobe, returns 10 cycles later.
    always @(posedge clk) begin
        if (en_a)             mcnt_a <= 1;
        else if (mcnt_a != 0) mcnt_a <= (mcnt_a == 12) ? 0 : mcnt_a + 1;
        if (en_b)             mcnt_b <= 1;
        else if (mcnt_b != 0) mcnt_b <= (mcnt_b == 12) ? 0 : mcnt_b + 1;
    end
    assign avail_a = !dead_a && !(mcnt_a >= 2 && mcnt_a < 12);
    assign avail_b = !(mcnt_b >= 2 && mcnt_b < 12);

    // Capture every strobed word and every done pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en_a) begin wq_a.push_back({cd_a, data_a}); iq_a.push_back(idx_a); end
        if (en_b) wq_b.push_back({cd_b, data_b});
        if (done_a) begin done_n_a <= done_n_a + 1; done_t_a.push_back(cyc); end
        if (done_b) done_n_b <= done_n_b + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle(input bit b, input int maxc, input string tag);
        int n = 0;
        while ((b ? busy_b : busy_a) && n < maxc) begin @(posedge clk); #1; n++; end
        chk(tag, b ? busy_b : busy_a, 0);
    endtask

    task automatic wait_words_a(input int target, input int maxc, input string tag);
        int n = 0;
        while (wq_a.size() < target && n < maxc) begin @(posedge clk); #1; n++; end
        chk(tag, wq_a.size(), target);
    endtask

    task automatic check_pass_a(input int base, input string tag);
        for (int i = 0; i < 5; i++) chk($sformatf("%s_w%0d", tag, i), wq_a[base+i], exp_a[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, d0;
        rst_n = 1'b0; start_a = 0; start_b = 0; rep_a = 0; dead_a = 1'b1;
        #12;
        chk("rst_data", data_a, 0);
        chk("rst_cd", cd_a, 1);
        chk("rst_en", en_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_idx", idx_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Dead driver: 5 startup cycles plus 20 waiting cycles, then ERROR.
        pulse(0);
        n = 0;
        while (!err_a && n < 40) begin @(posedge clk); #1; n++; end
        chk("tmo_lat", n, 25);
        chk("tmo_err", err_a, 1);
        chk("tmo_busy", busy_a, 0);
        chk("tmo_nostrobe", wq_a.size(), 0);
        chk("tmo_nodone", done_n_a, 0);

        // Driver restored: new start clears the flag and a full pass completes.
        dead_a = 1'b0;
        pulse(0);
        chk("err_clear", err_a, 0);
        chk("run_busy", busy_a, 1);
        wait_idle(0, 400, "t1_idle");
        chk("t1_count", wq_a.size(), 5);
        check_pass_a(0, "t1");
        chk("t1_idx0", iq_a[1], 0);
        chk("t1_idx1", iq_a[2], 1);
        chk("t1_idx2", iq_a[4], 2);
        chk("t1_done", done_n_a, 1);
        chk("t1_hold_data", data_a, 32'h4C4C2120);
        chk("t1_hold_cd", cd_a, 1);
        chk("t1_hold_idx", idx_a, 2);

        // Start re-pulsed mid-pass is ignored.
        base = wq_a.size(); d0 = done_n_a;
        pulse(0);
        wait_words_a(base + 3, 300, "t3_reach");
        pulse(0);
        wait_idle(0, 400, "t3_idle");
        repeat (20) @(posedge clk);
        #1;
        chk("t3_count", wq_a.size(), base + 5);
        check_pass_a(base, "t3");
        chk("t3_done", done_n_a, d0 + 1);
        chk("t3_stay_idle", busy_a, 0);

        // Reset during WAIT_DONE of the third word.
        base = wq_a.size();
        pulse(0);
        wait_words_a(base + 3, 300, "t5_reach");
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_en", en_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_cd", cd_a, 1);
        chk("t5_data", data_a, 0);
        chk("t5_idx", idx_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_quiet", wq_a.size(), base + 3);
        chk("t5_idle", busy_a, 0);

        // Repeat mode: two passes with the gap between them, then stop.
        rep_a = 1'b1;
        base = wq_a.size(); d0 = done_n_a;
        pulse(0);
        n = 0;
        while (done_n_a < d0 + 2 && n < 1000) begin @(posedge clk); #1; n++; end
        chk("t4_two_done", done_n_a, d0 + 2);
        rep_a = 1'b0;
        chk("t4_busy_gap", busy_a, 1);
        wait_idle(0, 300, "t4_stop");
        chk("t4_count", wq_a.size(), base + 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t4_w%0d", i), wq_a[base+i], exp_a[i%5]);
        chk("t4_done_total", done_n_a, d0 + 2);
        chk("t4_spacing", (done_t_a[done_t_a.size()-1] - done_t_a[done_t_a.size()-2]) >= 100, 1);

        // 2-byte words.
        pulse(1);
        wait_idle(1, 400, "t6_idle");
        chk("t6_count", wq_b.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_w%0d", i), wq_b[i], exp_b[i]);
        chk("t6_done", done_n_b, 1);
        chk("t6_err", err_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd_msg_sequencer.md
Name: lcd_msg_sequencer

Overview:
Parametrised message streamer that replaces the hard-coded three-chunk HELLO sequencer in the LCD test tops. It holds a packed ASCII message in a parameter and splits it into CHUNK_BYTES-wide words. Each word is pushed into the LCD driver through the selectCD/enableWriting/LCD_Available handshake. It also inserts clear and line-2 address commands, adds an optional repeat mode, and uses a handshake timeout so a dead driver is flagged instead of hanging the FSM.

Parameters:
CHUNK_BYTES, 4, characters per driver word; bus width is 8*CHUNK_BYTES
MSG_CHARS, 32, message length in characters; must be a multiple of CHUNK_BYTES and no more than 2*LINE_CHARS
LINE_CHARS, 16, characters per display line; must be a multiple of CHUNK_BYTES
MSG, 256'h20 repeated, packed message of 8*MSG_CHARS bits; the first character sits in the MSBs (Verilog string literal order)
STARTUP_CYCLES, 5, idle cycles after reset release before the first transfer
TIMEOUT_CYCLES, 65535, maximum cycles spent waiting in any handshake state
REPEAT_GAP, 50000000, idle cycles between repetitions when repeat_en=1

Ports:
clk  in  1  system clock (CLOCK_50 at top)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to send the message; ignored while busy=1
repeat_en  in  1  loop the message continuously after the first start
lcd_available  in  1  driver ready (LCD_Available)
lcd_data  out  8*CHUNK_BYTES  word to driver (data)
lcd_select_cd  out  1  1=character data, 0=command (selectCD)
lcd_enable_writing  out  1  one-cycle write strobe (enableWriting)
busy  out  1  a sequence is in progress
done  out  1  one-cycle pulse when the last word completes
timeout_err  out  1  sticky handshake-timeout flag
word_idx  out  8  index of the message chunk currently being sent

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0 except lcd_select_cd=1. All counters are cleared. Reset in the middle of a transfer drops lcd_enable_writing in the same instant, with no partial word.
- After rst_n rises the FSM stays in IDLE. A start pulse moves it to STARTUP, which waits STARTUP_CYCLES cycles and then goes to WAIT_READY.
- Word list per pass:
  - First, the CLEAR command: lcd_select_cd=0, lcd_data = 0x01 in the top byte, other bytes 0x00.
  - Then the chunks i = 0 to MSG_CHARS/CHUNK_BYTES-1 with lcd_select_cd=1. Chunk i is MSG[8*MSG_CHARS-1-8*CHUNK_BYTES*i -: 8*CHUNK_BYTES].
  - Immediately before the chunk whose first character index equals LINE_CHARS, insert the command 0xC0 (top byte, rest 0x00).
- States:
  - IDLE: waits for start.
  - STARTUP: counts STARTUP_CYCLES.
  - WAIT_READY: waits for lcd_available=1.
  - ISSUE: drives lcd_data and lcd_select_cd, and asserts lcd_enable_writing for exactly one cycle.
  - WAIT_ACCEPT: waits for lcd_available=0.
  - WAIT_DONE: waits for lcd_available=1.
  - NEXT: advances the pointer; goes to FINISH if the list is exhausted, otherwise to WAIT_READY.
  - FINISH: done=1 for one cycle, then either IDLE or GAP.
  - GAP: counts REPEAT_GAP cycles, then restarts the list at CLEAR.
  - ERROR: holds until the next start.
- lcd_data and lcd_select_cd are registered. They are set in ISSUE and held stable until the next ISSUE.
- Handshake: a word counts as complete only after lcd_available has fallen and then risen again. A lcd_available=1 level seen straight after the strobe is not treated as done.
- Timeout: a counter runs in WAIT_READY, WAIT_ACCEPT and WAIT_DONE and reloads on every state change. When it reaches TIMEOUT_CYCLES-1 the FSM goes to ERROR, sets timeout_err=1 and busy=0. timeout_err is cleared only by reset or by the next accepted start.
- busy=1 in every state other than IDLE and ERROR. It stays 1 through GAP.
- done and the last NEXT: done fires in FINISH, one cycle after the last NEXT. In repeat mode done fires once per pass.
- repeat_en is sampled in FINISH. If it is deasserted during GAP, the FSM returns to IDLE at the end of the gap.
- start while busy=1 has no effect. start in the same cycle that reset is released is ignored.
- word_idx counts chunks only; commands do not increment it. It is 0 during CLEAR, wraps to 0 when a new pass begins, and is stable while busy=0.

Test Plan:
Bench LCD model: it drops lcd_available 2 cycles after the strobe and raises it 10 cycles later.
1. MSG_CHARS=12, LINE_CHARS=8, MSG="HELLO WILL! ", start pulse -> the driver sees exactly five words in this order: 0x01000000/cd=0, "HELL"/cd=1, "O WI"/cd=1, 0xC0000000/cd=0, "LL! "/cd=1. Then one done pulse, then busy=0.
2. lcd_available held at 0 from reset with TIMEOUT_CYCLES=20 -> after start plus STARTUP_CYCLES, the FSM enters ERROR within 20 cycles, timeout_err=1, no strobe is ever issued. A second start with availability restored clears timeout_err and completes normally.
3. start re-pulsed at the 3rd word of test 1 -> the word sequence is unchanged and only one done pulse is seen.
4. repeat_en=1, REPEAT_GAP=100 -> CLEAR plus 4 words repeat. Consecutive done pulses are at least 100 cycles apart. Clearing repeat_en stops the loop after the current gap.
5. rst_n pulled low during WAIT_DONE of "O WI" -> lcd_enable_writing=0, busy=0, lcd_select_cd=1 immediately. After release, no activity occurs until start.
6. CHUNK_BYTES=2, MSG_CHARS=4, LINE_CHARS=2, MSG="ABCD" -> words in order: CLEAR, "AB", 0xC000, "CD". lcd_data is 16 bits wide.
